// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command driver: opcodes, FSM states and size defaults.
package alu_cmd_pkg;

    localparam int unsigned DW_DEF   = 4;
    localparam int unsigned NREG_DEF = 4;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_OR     = 4'd5;
    localparam logic [3:0] OP_XOR    = 4'd6;
    localparam logic [3:0] OP_RSHIFT = 4'd7;
    localparam logic [3:0] OP_LSHIFT = 4'd8;
    localparam logic [3:0] OP_XNOR   = 4'd9;
    localparam logic [3:0] OP_NOTA   = 4'd12;
    localparam logic [3:0] OP_NOTB   = 4'd13;
    localparam logic [3:0] OP_COMP   = 4'd14;
    localparam logic [3:0] OP_DIFF   = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_regfile.sv
// Register file for the ALU command driver: two combinational read ports, one synchronous write port.
module alu_cmd_regfile
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_i,
    input  logic [AW-1:0] rb_i,
    output logic [DW-1:0] ra_data_o,
    output logic [DW-1:0] rb_data_o,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i
);

    logic [DW-1:0] mem_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o = mem_q[ra_i];
    assign rb_data_o = mem_q[rb_i];

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequential initiator for the 4-bit combinational ALU (accept -> issue -> respond).
// Optional divide-by-zero guard and rsp_err port enabled by ALU_CMD_DIVZ_GUARD_EN.
module alu_cmd_driver
    import alu_cmd_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_opr,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic          cmd_use_imm,
    input  logic [DW-1:0] cmd_imm,
    output logic [3:0]    alu_opr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_o,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
`ifdef ALU_CMD_DIVZ_GUARD_EN
    output logic          rsp_err,
`endif
    output logic [AW-1:0] rsp_rd
);

    state_t        state_q, state_d;
    logic [3:0]    opr_q;
    logic [DW-1:0] a_q, b_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] rsp_data_q;
    logic [AW-1:0] rsp_rd_q;
    logic [DW-1:0] ra_data, rb_data, b_sel, result;
    logic          accept, we;

    alu_cmd_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .ra_i      (cmd_ra),
        .rb_i      (cmd_rb),
        .ra_data_o (ra_data),
        .rb_data_o (rb_data),
        .we_i      (we),
        .wa_i      (rd_q),
        .wd_i      (result)
    );

    assign b_sel  = cmd_use_imm ? cmd_imm : rb_data;
    assign accept = (state_q == IDLE) && cmd_valid;

`ifdef ALU_CMD_DIVZ_GUARD_EN
    logic divz_q, err_q;
    // Divide-by-zero is decided at accept time from the resolved B operand.
    assign result  = divz_q ? '1 : alu_o;
    assign rsp_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divz_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) divz_q <= (cmd_opr == OP_DIV) && (b_sel == '0);
            if (we)     err_q  <= divz_q;
        end
    end
`else
    assign result = alu_o;
`endif

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = ISSUE;
            ISSUE: begin
                we      = 1'b1;
                state_d = RESP;
            end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opr_q <= cmd_opr;
                a_q   <= ra_data;
                b_q   <= b_sel;
                rd_q  <= cmd_rd;
            end
            if (we) begin
                rsp_data_q <= result;
                rsp_rd_q   <= rd_q;
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_opr   = opr_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed scoreboard bench for alu_cmd_driver; includes a behavioural 4-bit ALU.
// Divide-by-zero guard steps are compiled in with ALU_CMD_DIVZ_GUARD_EN.
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_opr = '0;
    logic [1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic       cmd_use_imm = 1'b0;
    logic [3:0] cmd_imm = '0;
    logic [3:0] alu_opr, alu_a, alu_b, alu_o;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
    logic [1:0] rsp_rd;
`ifdef ALU_CMD_DIVZ_GUARD_EN
    logic       rsp_err;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic [3:0] opr;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] data;
        logic [1:0] rd;
        logic       err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_cmd_driver dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opr     (cmd_opr),
        .cmd_rd      (cmd_rd),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .alu_opr     (alu_opr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_o       (alu_o),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
`ifdef ALU_CMD_DIVZ_GUARD_EN
        .rsp_err     (rsp_err),
`endif
        .rsp_rd      (rsp_rd)
    );

    // Behavioural ALU; division by zero yields 0 so the guard is distinguishable.
    function automatic logic [3:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                             input logic [3:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 4'd0) ? 4'd0 : a / b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a >> b;
            4'd8:    return a << b;
            4'd9:    return ~(a ^ b);
            4'd12:   return ~a;
            4'd13:   return ~b;
            4'd14:   return {3'd0, a == b};
            4'd15:   return {3'd0, a != b};
            default: return 4'd0;
        endcase
    endfunction

    always_comb alu_o = alu_model(alu_opr, alu_a, alu_b);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [3:0] opr, input logic [1:0] rd, input logic [1:0] ra,
                             input logic [1:0] rb, input logic ui, input logic [3:0] imm,
                             input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ed,
                             input logic eerr);
        int n = 0;
        sb.push_back('{opr: opr, a: ea, b: eb, data: ed, rd: rd, err: eerr});
        cmd_opr = opr; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
        cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {7'd0, cmd_ready}, 8'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag);
        exp_t e;
        int   n = 0;
        e = sb.pop_front();
        @(negedge clk);
        n++;
        chk({tag, "_issue_opr"}, {4'd0, alu_opr}, {4'd0, e.opr});
        chk({tag, "_issue_a"},   {4'd0, alu_a},   {4'd0, e.a});
        chk({tag, "_issue_b"},   {4'd0, alu_b},   {4'd0, e.b});
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n[7:0], 8'd2);
        chk({tag, "_data"}, {4'd0, rsp_data}, {4'd0, e.data});
        chk({tag, "_rd"},   {6'd0, rsp_rd},   {6'd0, e.rd});
`ifdef ALU_CMD_DIVZ_GUARD_EN
        chk({tag, "_err"},  {7'd0, rsp_err},  {7'd0, e.err});
`endif
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_alu", {alu_opr, alu_a}, 8'h00);
        chk("rst_alu_b", {4'd0, alu_b}, 8'h00);
        chk("rst_rsp", {rsp_data, 2'd0, rsp_rd}, 8'h00);

        start_cmd(4'd1, 2'd3, 2'd0, 2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0);
        get_rsp("sub_r0r0");
        start_cmd(4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5, 4'd0, 4'd5, 4'h5, 1'b0);
        get_rsp("add_imm5");
        start_cmd(4'd1, 2'd2, 2'd1, 2'd0, 1'b1, 4'd7, 4'd5, 4'd7, 4'hE, 1'b0);
        get_rsp("sub_imm7");
        start_cmd(4'd2, 2'd3, 2'd1, 2'd0, 1'b1, 4'd4, 4'd5, 4'd4, 4'h4, 1'b0);
        get_rsp("mul_wrap");
        start_cmd(4'd14, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0, 4'd5, 4'd5, 4'h1, 1'b0);
        get_rsp("comp_eq");
        start_cmd(4'd15, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0, 4'd5, 4'd5, 4'h0, 1'b0);
        get_rsp("diff_eq");
        start_cmd(4'd10, 2'd3, 2'd1, 2'd0, 1'b1, 4'd3, 4'd5, 4'd3, 4'h0, 1'b0);
        get_rsp("op10");
        start_cmd(4'd0, 2'd3, 2'd2, 2'd1, 1'b0, 4'd0, 4'hE, 4'd5, 4'h3, 1'b0);
        get_rsp("add_regs");

        // Backpressure: response held 5 cycles while the next command waits
        rsp_ready = 1'b0;
        start_cmd(4'd6, 2'd2, 2'd1, 2'd0, 1'b1, 4'd3, 4'd5, 4'd3, 4'h6, 1'b0);
        get_rsp("xor_hold");
        cmd_opr = 4'd0; cmd_rd = 2'd0; cmd_ra = 2'd2; cmd_use_imm = 1'b1;
        cmd_imm = 4'd1; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {7'd0, rsp_valid}, 8'd1);
            chk("hold_rsp", {rsp_data, 2'd0, rsp_rd}, {4'h6, 4'd2});
            chk("hold_cmd_ready", {7'd0, cmd_ready}, 8'd0);
            chk("hold_alu", {alu_opr, alu_a}, {4'd6, 4'd5});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_ready", {7'd0, cmd_ready}, 8'd1);
        chk("post_hs_valid", {7'd0, rsp_valid}, 8'd0);
        chk("post_hs_alu", {alu_opr, alu_a}, {4'd6, 4'd5});
        start_cmd(4'd0, 2'd0, 2'd2, 2'd0, 1'b1, 4'd1, 4'd6, 4'd1, 4'h7, 1'b0);
        get_rsp("add_after_hold");

`ifdef ALU_CMD_DIVZ_GUARD_EN
        start_cmd(4'd3, 2'd1, 2'd1, 2'd0, 1'b1, 4'd0, 4'd5, 4'd0, 4'hF, 1'b1);
        get_rsp("div_zero_guard");
        start_cmd(4'd3, 2'd3, 2'd1, 2'd0, 1'b1, 4'd2, 4'hF, 4'd2, 4'h7, 1'b0);
        get_rsp("div_after_guard");
`else
        start_cmd(4'd3, 2'd3, 2'd1, 2'd0, 1'b1, 4'd0, 4'd5, 4'd0, 4'h0, 1'b0);
        get_rsp("div_zero_raw");
`endif

        // Reset during ISSUE
        cmd_opr = 4'd0; cmd_rd = 2'd2; cmd_ra = 2'd0; cmd_use_imm = 1'b1;
        cmd_imm = 4'd9; cmd_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        chk("pre_rst_issue", {7'd0, cmd_ready}, 8'd0);
        rst = 1'b1;
        #1;
        chk("rst_issue_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_issue_ready", {7'd0, cmd_ready}, 8'd1);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rst_rel_valid", {7'd0, rsp_valid}, 8'd0);
        start_cmd(4'd0, 2'd3, 2'd2, 2'd0, 1'b1, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0);
        get_rsp("r2_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential initiator that drives the 4-bit combinational ALU. It accepts register-level commands over a valid/ready port, reads operands from a small local register file, and presents opcode and operands to the ALU. It then captures the ALU result, writes it back, and returns it over a valid/ready response port. It is the controller side of the ALU's `opr/a/b -> o` interface.

## Interface
- `DW`, 4, data width; matches the ALU operand and result width.
- `NREG`, 4, register-file depth; register index width is log2(NREG) = 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  driver can accept a command.
- `cmd_opr`  in  4  ALU opcode, passed through unchanged.
- `cmd_rd`, `cmd_ra`, `cmd_rb`  in  2 each  destination, source-A and source-B register indices.
- `cmd_use_imm`  in  1  when 1, operand B is `cmd_imm` instead of `reg[cmd_rb]`.
- `cmd_imm`  in  DW  immediate operand.
- `alu_opr`  out  4  registered opcode to the ALU.
- `alu_a`, `alu_b`  out  DW  registered operands to the ALU.
- `alu_o`  in  DW  combinational ALU result.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  DW  captured result.
- `rsp_rd`  out  2  destination index that was written.
- `rsp_err`  out  1  divide-by-zero flag; exists only with the macro (see Configuration).

## Operation
- FSM states:
  - IDLE: `cmd_ready=1`.
    - On `cmd_valid`, latch `alu_opr=cmd_opr`, `alu_a=reg[cmd_ra]`, `alu_b=cmd_use_imm?cmd_imm:reg[cmd_rb]` and `rd`, then go to ISSUE.
  - ISSUE: ALU inputs are stable for this whole cycle.
    - At the end of the cycle, `reg[rd]<=alu_o`, `rsp_data<=alu_o`, `rsp_rd<=rd`, then go to RESP.
  - RESP: `rsp_valid=1`.
    - On `rsp_ready`, go to IDLE.
    - Without `rsp_ready`, hold every output.
- `cmd_ready` is combinational and equals (state==IDLE). It is 0 in ISSUE and RESP, so only one command is in flight.
- All `NREG` registers are writable; none is hardwired.
- Results are the ALU's DW-bit truncated values:
  - add, sub and mul wrap mod 2^DW.
  - comp and diff give 0 or 1.
  - Reserved opcodes 10 and 11 return 0.
  - The driver does not reinterpret any result.
- Operands are read at accept time, so a command reading the register written by the previous command sees the new value.
- `alu_*` hold their last value between commands.

## Timing
- Reset values: state IDLE; all registers 0; `alu_opr`, `alu_a`, `alu_b` 0; `rsp_valid` 0; `rsp_data`, `rsp_rd`, `rsp_err` 0; `cmd_ready` 1.
- Latency: if accept is at edge E0, the write-back and `rsp_valid` rise at E1 and are visible from E1.
- Minimum initiation interval: 3 cycles (accept, issue, respond with `rsp_ready=1`).
- `cmd_valid` may drop without being accepted; no command is latched outside IDLE.
- Reset asserted in any state returns to reset values immediately:
  - Reset in ISSUE: no register write-back occurs.
  - Reset in RESP: the response is lost.

## Configuration
- `ALU_CMD_DIVZ_GUARD_EN` defined:
  - Port `rsp_err` exists.
  - If the accepted command has opcode 3 (div) and the resolved B is 0, the driver still sequences ISSUE, but captures all-ones (4'hF) instead of `alu_o` and sets `rsp_err=1`.
  - `rsp_err` is 0 for every other command.
- `ALU_CMD_DIVZ_GUARD_EN` undefined:
  - No `rsp_err` port.
  - Divide-by-zero captures `alu_o` unmodified.

## Structure
- Package `alu_cmd_pkg` holds:
  - Opcode constants ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, RSHIFT=7, LSHIFT=8, XNOR=9, NOTA=12, NOTB=13, COMP=14, DIFF=15.
  - The FSM state enum {IDLE, ISSUE, RESP}.
  - The DW and NREG defaults.
- One sub-module: `alu_cmd_regfile`, with 2 combinational read ports, 1 synchronous write port and asynchronous reset to 0.

## Test plan
- Reset, then idle for 3 cycles -> `cmd_ready=1`, `rsp_valid=0`, all `alu_*`=0, and a SUB r3=r0-r0 returns 0.
- ADD r1=r0+imm 5 -> `rsp_data=5`, `rsp_rd=1`, `rsp_valid` 1 cycle after accept. Then SUB r2=r1-imm 7 -> `rsp_data=4'hE`.
- With r1=5: MUL r1*imm 4 -> 4'h4 (truncated); COMP r1,r1 -> 1; DIFF r1,r1 -> 0; opcode 10 -> 0.
- Hold `rsp_ready=0` for 5 cycles in RESP -> `rsp_valid`, `rsp_data` and `rsp_rd` stable, `cmd_ready=0`, and a held `cmd_valid` is not accepted until 1 cycle after the response handshake.
- With `ALU_CMD_DIVZ_GUARD_EN`: DIV r1/imm 0 -> `rsp_data=4'hF`, `rsp_err=1`, r1 written F. Then DIV imm 2 with r1=F -> 7, `rsp_err=0`.
- Assert `rst` during ISSUE of ADD r2=r0+imm 9 -> r2 stays 0, `rsp_valid=0`, state IDLE after reset releases.
